// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the multi-lane PIPE MAC-side controller.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DET_SETUP,
        ST_DET_WAIT,
        ST_DET_END,
        ST_PD_WAIT,
        ST_RATE_WAIT
    } state_e;

    typedef enum logic [3:0] {
        PD_P0  = 4'd0,
        PD_P0S = 4'd1,
        PD_P1  = 4'd2,
        PD_P2  = 4'd3
    } pd_e;

    localparam logic [2:0] RXSTAT_DETECTED = 3'b011;
    localparam logic [2:0] GEN_MIN         = 3'd1;
    localparam logic [2:0] GEN_MAX         = 3'd5;

    // Generations outside 1..5 never trigger a rate change.
    function automatic logic gen_valid(input logic [2:0] gen);
        return (gen >= GEN_MIN) && (gen <= GEN_MAX);
    endfunction

endpackage

// File: rtl/pipe_lane_detect.sv
// Per-lane receiver-detect tracking: seen/present flags and detect strobe gating.
module pipe_lane_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       pclk,
    input  logic       reset,
    input  logic       i_clear,
    input  logic       i_active,
    input  logic       i_strobe_en,
    input  logic       i_phystatus,
    input  logic [2:0] i_rxstatus,
    output logic       o_seen,
    output logic       o_present,
    output logic       o_strobe
);

    logic r_seen;
    logic r_present;
    logic r_strobe;
    logic w_seen_next;
    logic w_present_next;

    // Only the first PhyStatus of a detect round is recorded.
    always_comb begin
        w_seen_next    = r_seen;
        w_present_next = r_present;
        if (i_clear) begin
            w_seen_next    = 1'b0;
            w_present_next = 1'b0;
        end else if (i_active && i_phystatus && !r_seen) begin
            w_seen_next    = 1'b1;
            w_present_next = (i_rxstatus == RXSTAT_DETECTED);
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r_seen    <= 1'b0;
            r_present <= 1'b0;
            r_strobe  <= 1'b0;
        end else begin
            r_seen    <= w_seen_next;
            r_present <= w_present_next;
            r_strobe  <= i_strobe_en && !w_seen_next;
        end
    end

    assign o_seen    = r_seen;
    assign o_present = r_present;
    assign o_strobe  = r_strobe;

endmodule

// File: rtl/pipe_ctrl_multilane.sv
// Multi-lane PIPE MAC-side controller: receiver detect, PowerDown and Rate
// changes, each completed by PhyStatus or a bounded timeout.
module pipe_ctrl_multilane
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned LANES          = 4,
    parameter int unsigned PD_WIDTH       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  pclk,
    input  logic                  reset,
    input  logic [2:0]            generation,
    input  logic                  detect_req,
    input  logic                  elecidle_req,
    input  logic                  pd_req,
    input  logic [PD_WIDTH-1:0]   pd_target,
    input  logic [LANES-1:0]      PhyStatus,
    input  logic [3*LANES-1:0]    RxStatus,
    output logic [LANES-1:0]      TxDetectRx_Loopback,
    output logic [LANES-1:0]      TxElecIdle,
    output logic [PD_WIDTH-1:0]   PowerDown,
    output logic [2:0]            Rate,
    output logic                  busy,
    output logic                  detect_done,
    output logic [LANES-1:0]      detect_result,
    output logic                  op_done,
    output logic                  timeout_err
);

    localparam int unsigned      CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    state_e               r_state, w_state_next;
    logic [CNT_W-1:0]     r_cnt, w_cnt_next;
    logic [PD_WIDTH-1:0]  r_pd, w_pd_next;
    logic [2:0]           r_rate, w_rate_next;
    logic [2:0]           r_gen_q, w_gen_q_next;
    logic [LANES-1:0]     r_txei, w_txei_next;
    logic [LANES-1:0]     r_result, w_result_next;
    logic                 r_det_done, w_det_done_next;
    logic                 r_op_done, w_op_done_next;
    logic                 r_to_err, w_to_err_next;
    logic                 r_to_flag, w_to_flag_next;
    logic                 r_pd_same, w_pd_same_next;
    logic                 r_busy;

    logic [LANES-1:0]     w_seen;
    logic [LANES-1:0]     w_present;
    logic [LANES-1:0]     w_strobe;
    logic                 w_timeout;
    logic                 w_rate_pending;
    logic                 w_strobe_en;

    assign w_timeout      = (r_cnt == CNT_MAX);
    assign w_rate_pending = gen_valid(generation) && (generation != r_gen_q);
    assign w_strobe_en    = (w_state_next == ST_DET_WAIT);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        pipe_lane_detect u_lane (
            .pclk        (pclk),
            .reset       (reset),
            .i_clear     (r_state == ST_DET_SETUP),
            .i_active    (r_state == ST_DET_WAIT),
            .i_strobe_en (w_strobe_en),
            .i_phystatus (PhyStatus[i]),
            .i_rxstatus  (RxStatus[3*i +: 3]),
            .o_seen      (w_seen[i]),
            .o_present   (w_present[i]),
            .o_strobe    (w_strobe[i])
        );
    end

    // Next-state and next-output logic; completion wins over a same-cycle timeout.
    always_comb begin
        w_state_next    = r_state;
        w_pd_next       = r_pd;
        w_rate_next     = r_rate;
        w_gen_q_next    = r_gen_q;
        w_result_next   = r_result;
        w_to_flag_next  = r_to_flag;
        w_pd_same_next  = r_pd_same;
        w_det_done_next = 1'b0;
        w_op_done_next  = 1'b0;
        w_to_err_next   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (detect_req) begin
                    w_state_next = ST_DET_SETUP;
                    w_pd_next    = PD_WIDTH'(PD_P1);
                end else if (pd_req) begin
                    w_state_next   = ST_PD_WAIT;
                    w_pd_next      = pd_target;
                    w_pd_same_next = (pd_target == r_pd);
                end else if (w_rate_pending) begin
                    w_state_next = ST_RATE_WAIT;
                    w_rate_next  = generation - 3'd1;
                    w_gen_q_next = generation;
                end
            end
            ST_DET_SETUP: begin
                w_state_next   = ST_DET_WAIT;
                w_to_flag_next = 1'b0;
            end
            ST_DET_WAIT: begin
                if (&w_seen) begin
                    w_state_next = ST_DET_END;
                end else if (w_timeout) begin
                    w_state_next   = ST_DET_END;
                    w_to_flag_next = 1'b1;
                end
            end
            ST_DET_END: begin
                w_state_next    = ST_IDLE;
                w_result_next   = w_present;
                w_det_done_next = 1'b1;
                w_to_err_next   = r_to_flag;
            end
            ST_PD_WAIT, ST_RATE_WAIT: begin
                if (((r_state == ST_PD_WAIT) && r_pd_same) || (|PhyStatus)) begin
                    w_state_next   = ST_IDLE;
                    w_op_done_next = 1'b1;
                end else if (w_timeout) begin
                    w_state_next   = ST_IDLE;
                    w_op_done_next = 1'b1;
                    w_to_err_next  = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        if (w_state_next != r_state) begin
            w_cnt_next = '0;
        end else if (w_timeout) begin
            w_cnt_next = r_cnt;
        end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end

        if ((w_state_next == ST_DET_SETUP) || (w_state_next == ST_DET_WAIT) ||
            (w_state_next == ST_DET_END)) begin
            w_txei_next = '1;
        end else begin
            w_txei_next = {LANES{elecidle_req}};
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_pd       <= PD_WIDTH'(PD_P1);
            r_rate     <= 3'd0;
            r_gen_q    <= 3'd1;
            r_txei     <= '1;
            r_result   <= '0;
            r_det_done <= 1'b0;
            r_op_done  <= 1'b0;
            r_to_err   <= 1'b0;
            r_to_flag  <= 1'b0;
            r_pd_same  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_pd       <= w_pd_next;
            r_rate     <= w_rate_next;
            r_gen_q    <= w_gen_q_next;
            r_txei     <= w_txei_next;
            r_result   <= w_result_next;
            r_det_done <= w_det_done_next;
            r_op_done  <= w_op_done_next;
            r_to_err   <= w_to_err_next;
            r_to_flag  <= w_to_flag_next;
            r_pd_same  <= w_pd_same_next;
            r_busy     <= (w_state_next != ST_IDLE);
        end
    end

    assign TxDetectRx_Loopback = w_strobe;
    assign TxElecIdle          = r_txei;
    assign PowerDown           = r_pd;
    assign Rate                = r_rate;
    assign busy                = r_busy;
    assign detect_done         = r_det_done;
    assign detect_result       = r_result;
    assign op_done             = r_op_done;
    assign timeout_err         = r_to_err;

endmodule

// File: doc/pipe_ctrl_multilane.md
Name: pipe_ctrl_multilane

Overview:
- Parametrised multi-lane PIPE MAC-side controller; owns receiver detect, PowerDown changes and Rate changes for LANES PHY lanes.
- Sits between the LTSSM (request/status side) and the PIPE PHY interface.
- Beyond single-lane detect, it adds:
  - per-lane detect results;
  - a PhyStatus timeout;
  - PowerDown handshake sequencing;
  - generation-driven Rate change with PhyStatus completion.

Parameters:
- LANES, 4, number of PIPE lanes (1..16).
- PD_WIDTH, 4, PowerDown encoding width.
- TIMEOUT_CYCLES, 1024, max pclk cycles waiting for PhyStatus per operation.
- CNT_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived).

Ports:
- pclk  in  1  PIPE clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- generation  in  3  target generation, 1..5; other values are held off (no change).
- detect_req  in  1  single-cycle pulse; start receiver detect.
- elecidle_req  in  1  level; request TX electrical idle.
- pd_req  in  1  single-cycle pulse; start PowerDown change to pd_target.
- pd_target  in  PD_WIDTH  requested PowerDown state, sampled with pd_req.
- PhyStatus  in  LANES  per-lane PHY completion pulse.
- RxStatus  in  3*LANES  per-lane status; lane i at bits [3i+2:3i].
- TxDetectRx_Loopback  out  LANES  detect strobe per lane.
- TxElecIdle  out  LANES  per-lane TX electrical idle.
- PowerDown  out  PD_WIDTH  PHY power state.
- Rate  out  3  generation-1 encoding.
- busy  out  1  high whenever FSM is not in IDLE.
- detect_done  out  1  one-cycle pulse at end of detect.
- detect_result  out  LANES  bit i = receiver present on lane i; held until the next detect completes.
- op_done  out  1  one-cycle pulse at end of a PowerDown or Rate operation.
- timeout_err  out  1  one-cycle pulse, coincident with detect_done or op_done, when a timeout ended the operation.

Behaviour:
- Reset values:
  - PowerDown=4'b0010 (P1).
  - TxElecIdle all 1.
  - TxDetectRx_Loopback 0.
  - Rate=0.
  - detect_result 0.
  - busy, detect_done, op_done, timeout_err all 0.
  - FSM in IDLE; internal gen_q=1.
- Reset mid-operation: aborts immediately to the reset values; no done pulse.
- FSM states: IDLE, DET_SETUP, DET_WAIT, DET_END, PD_WAIT, RATE_WAIT.
- IDLE:
  - TxElecIdle = {LANES{elecidle_req}}, registered (1-cycle latency).
  - Request priority when simultaneous: detect_req > pd_req > rate change (a rate change is pending when generation != gen_q and generation is 1..5).
  - Any pending request moves the FSM out of IDLE on the next edge.
  - detect_req/pd_req arriving while busy are dropped. A pending rate change persists and is serviced on the next IDLE cycle.
- DET_SETUP (1 cycle):
  - PowerDown=P1 and TxElecIdle all 1.
  - Clear per-lane seen/present flags and the timeout counter.
  - Next state: DET_WAIT.
- DET_WAIT:
  - TxDetectRx_Loopback high on every lane whose seen flag is 0.
  - On PhyStatus[i]=1: set seen[i]; set present[i] if RxStatus lane i == 3'b011; deassert that lane's strobe on the next edge.
  - Multiple lanes may complete in the same cycle.
  - Exit to DET_END when all seen flags are set, or when the counter reaches TIMEOUT_CYCLES (timeout flag set; unseen lanes report 0).
- DET_END (1 cycle):
  - All strobes 0.
  - detect_result <= present; pulse detect_done (and timeout_err if the timeout flag is set).
  - Next state: IDLE.
- PD_WAIT:
  - On entry, PowerDown <= pd_target.
  - Wait for the OR of PhyStatus (any lane) or timeout.
  - Then pulse op_done (+ timeout_err on timeout) and return to IDLE.
  - If pd_target equals the current PowerDown: pulse op_done one cycle after entry without waiting.
- RATE_WAIT:
  - On entry, Rate <= generation-1 and gen_q <= generation.
  - Completion is identical to PD_WAIT (any-lane PhyStatus or timeout).
- Timeout counter:
  - Saturating, CNT_W bits; cleared on every state entry.
  - Timeout fires when it equals TIMEOUT_CYCLES.
- TxElecIdle is forced to all 1 in the DET_* states; it follows elecidle_req in every other state.
- PhyStatus seen in IDLE is ignored.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - FSM state enum.
  - PowerDown constants PD_P0=0, PD_P0S=1, PD_P1=2, PD_P2=3.
  - RXSTAT_DETECTED=3'b011.
- One natural sub-module: pipe_lane_detect, instantiated LANES times. It holds the per-lane seen/present flags and strobe gating.

Test Plan:
- Reset with LANES=4: assert reset mid-DET_WAIT -> PowerDown=2, TxElecIdle=4'hF, strobes 0, busy 0, no detect_done.
- Detect, all present: detect_req, PhyStatus lanes 0..3 on cycles 3,4,4,6 with RxStatus=3'b011 -> detect_done pulse, detect_result=4'hF, timeout_err 0, each lane's strobe drops the cycle after its PhyStatus.
- Partial detect plus timeout (TIMEOUT_CYCLES=16): lanes 0,2 respond (RxStatus 011 and 000); lanes 1,3 never respond -> detect_done with timeout_err at cycle 17+setup, detect_result=4'h1.
- PowerDown: pd_req with pd_target=0, lane-2 PhyStatus 5 cycles later -> PowerDown=0 one cycle after request, op_done on PhyStatus cycle +1; repeat with pd_target=0 -> op_done with no PhyStatus.
- Rate and priority: generation 1->3 in the same cycle as detect_req -> detect runs first; after DET_END, RATE_WAIT sets Rate=2; detect_req during RATE_WAIT is dropped; invalid generation=7 leaves Rate unchanged.
